// File: rtl/wb_pwm_pkg.sv
// Register map and shared helpers for the Wishbone PWM controller.
package wb_pwm_pkg;

    localparam int unsigned WB_DW = 32;
    localparam int unsigned REG_IDX_W = 2;

    // Word index of each register (byte offsets 0x0, 0x4, 0x8, 0xC)
    localparam logic [REG_IDX_W-1:0] REG_CTRL   = 2'd0;
    localparam logic [REG_IDX_W-1:0] REG_PERIOD = 2'd1;
    localparam logic [REG_IDX_W-1:0] REG_DUTY   = 2'd2;
    localparam logic [REG_IDX_W-1:0] REG_STATUS = 2'd3;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_INV_BIT    = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT = 2;
    localparam int unsigned WRAP_BIT        = 31;

    // Replace the byte lanes of old that are enabled in sel.
    function automatic logic [WB_DW-1:0] byte_merge(input logic [WB_DW-1:0] old,
                                                    input logic [WB_DW-1:0] wdat,
                                                    input logic [3:0]       sel);
        logic [WB_DW-1:0] res;
        res = old;
        for (int unsigned b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = wdat[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_core.sv
// PWM engine: counter, shadow-to-active load, duty compare and registered output.
module pwm_core #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             inv_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] duty_i,
    output logic             pwm_o,
    output logic             wrap_c_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;
    logic             running;
    logic             raw;

    // Active period/duty follow the shadows while idle and only re-sample at a wrap while running.
    always_comb begin
        running  = en_i && (per_q != '0);
        wrap_c_o = running && (cnt_q == per_q - CNT_W'(1));
        raw      = (per_q != '0) && (cnt_q < duty_q);
        per_d    = per_q;
        duty_d   = duty_q;
        cnt_d    = '0;
        if (!en_i || wrap_c_o) begin
            per_d  = period_i;
            duty_d = duty_i;
        end
        if (running && !wrap_c_o) cnt_d = cnt_q + CNT_W'(1);
        pwm_d = en_i & (raw ^ inv_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            per_q  <= '0;
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            per_q  <= per_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;
    assign cnt_o = cnt_q;

endmodule

// File: rtl/wb_pwm_ctrl.sv
// Wishbone-classic slave with CTRL/PERIOD/DUTY/STATUS registers driving one PWM pad.
module wb_pwm_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        pwm_o,
    output logic        pwm_oeb_o,
    output logic        irq_o
);
    import wb_pwm_pkg::*;

    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;
    logic             en_q, en_d;
    logic             inv_q, inv_d;
    logic             irq_en_q, irq_en_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic             wrap_q, wrap_d;
    logic             hit, acc, wr;
    logic [31:0]      rdata;
    logic             wrap_c;
    logic [CNT_W-1:0] cnt;
    logic             unused_adr;

    assign unused_adr = ^wbs_adr_i[1:0];

    // One ack per access: a held strobe is accepted only while no ack is outstanding.
    assign hit = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign acc = hit && !ack_q;
    assign wr  = acc && wbs_we_i;

    always_comb begin
        en_d     = en_q;
        inv_d    = inv_q;
        irq_en_d = irq_en_q;
        period_d = period_q;
        duty_d   = duty_q;
        wrap_d   = wrap_q;
        rdata    = '0;

        case (wbs_adr_i[3:2])
            REG_CTRL: begin
                rdata[CTRL_EN_BIT]     = en_q;
                rdata[CTRL_INV_BIT]    = inv_q;
                rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
            end
            REG_PERIOD: rdata = 32'(period_q);
            REG_DUTY:   rdata = 32'(duty_q);
            default: begin
                rdata           = 32'(cnt);
                rdata[WRAP_BIT] = wrap_q;
            end
        endcase

        if (wr) begin
            case (wbs_adr_i[3:2])
                REG_CTRL: begin
                    if (wbs_sel_i[0]) begin
                        en_d     = wbs_dat_i[CTRL_EN_BIT];
                        inv_d    = wbs_dat_i[CTRL_INV_BIT];
                        irq_en_d = wbs_dat_i[CTRL_IRQ_EN_BIT];
                    end
                end
                REG_PERIOD: period_d = CNT_W'(byte_merge(32'(period_q), wbs_dat_i, wbs_sel_i));
                REG_DUTY:   duty_d   = CNT_W'(byte_merge(32'(duty_q), wbs_dat_i, wbs_sel_i));
                default: begin
                    if (wbs_sel_i[3] && wbs_dat_i[WRAP_BIT]) wrap_d = 1'b0;
                end
            endcase
        end

        // A wrap in the same cycle as a clear keeps the flag set.
        if (wrap_c) wrap_d = 1'b1;

        ack_d = acc;
        dat_d = (acc && !wbs_we_i) ? rdata : '0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            en_q     <= 1'b0;
            inv_q    <= 1'b0;
            irq_en_q <= 1'b0;
            period_q <= '0;
            duty_q   <= '0;
            wrap_q   <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            en_q     <= en_d;
            inv_q    <= inv_d;
            irq_en_q <= irq_en_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            wrap_q   <= wrap_d;
        end
    end

    pwm_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk_i    (wb_clk_i),
        .rst_ni   (wb_rst_ni),
        .en_i     (en_q),
        .inv_i    (inv_q),
        .period_i (period_q),
        .duty_i   (duty_q),
        .pwm_o    (pwm_o),
        .wrap_c_o (wrap_c),
        .cnt_o    (cnt)
    );

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign pwm_oeb_o = ~en_q;
    assign irq_o     = wrap_q & irq_en_q;

endmodule

// File: tb/tb_wb_pwm_ctrl.sv
// Bench for wb_pwm_ctrl: register vectors, directed PWM/WRAP sequences and random traffic vs. a cycle model.
module tb_wb_pwm_ctrl;

    localparam logic [31:0] BASE     = 32'h3000_0000;
    localparam int unsigned CNT_W    = 16;
    localparam logic [31:0] CNT_MASK = 32'h0000_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, dat = '0;
    logic        wbs_ack_o, pwm_o, pwm_oeb_o, irq_o;
    logic [31:0] wbs_dat_o;

    int n_checks = 0;
    int n_err = 0;

    // Behavioural model: register image, phase within the running period and latched period/duty.
    logic        m_en, m_inv, m_irqen, m_wrap, m_ack, m_pwm;
    logic [31:0] m_per, m_duty, m_pact, m_dact, m_phase, m_dat;

    wb_pwm_ctrl #(.BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .pwm_o     (pwm_o),
        .pwm_oeb_o (pwm_oeb_o),
        .irq_o     (irq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_inv = 0; m_irqen = 0; m_wrap = 0; m_ack = 0; m_pwm = 0;
        m_per = 0; m_duty = 0; m_pact = 0; m_dact = 0; m_phase = 0; m_dat = 0;
    endtask

    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r = (r & ~(32'hFF << (8*b))) | (d & (32'hFF << (8*b)));
        return r & CNT_MASK;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] off);
        case (off)
            2'd0:    return {29'd0, m_irqen, m_inv, m_en};
            2'd1:    return m_per;
            2'd2:    return m_duty;
            default: return (32'(m_wrap) << 31) | m_phase;
        endcase
    endfunction

    // Advance the model across one rising edge using the inputs held before it.
    task automatic model_step();
        logic        hit, acc, wrap_ev, nxt_pwm;
        logic [31:0] rd;
        hit     = cyc && stb && ((adr >> 4) == (BASE >> 4));
        acc     = hit && !m_ack;
        rd      = (acc && !we) ? model_read(adr[3:2]) : 32'd0;
        nxt_pwm = m_en && (((m_pact != 0) && (m_phase < m_dact)) ^ m_inv);
        wrap_ev = 0;
        if (!m_en) begin
            m_phase = 0; m_pact = m_per; m_dact = m_duty;
        end else if (m_pact != 0) begin
            if (m_phase + 1 == m_pact) begin
                wrap_ev = 1; m_phase = 0; m_pact = m_per; m_dact = m_duty;
            end else begin
                m_phase = m_phase + 1;
            end
        end
        if (acc && we) begin
            case (adr[3:2])
                2'd0: if (sel[0]) begin m_en = dat[0]; m_inv = dat[1]; m_irqen = dat[2]; end
                2'd1: m_per  = lane_merge(m_per, dat, sel);
                2'd2: m_duty = lane_merge(m_duty, dat, sel);
                default: if (sel[3] && dat[31]) m_wrap = 0;
            endcase
        end
        if (wrap_ev) m_wrap = 1;
        m_ack = acc;
        m_dat = rd;
        m_pwm = nxt_pwm;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_step();
        @(negedge clk);
        chk("ack",   32'(wbs_ack_o), 32'(m_ack));
        chk("dat_o", wbs_dat_o, m_dat);
        chk("pwm",   32'(pwm_o), 32'(m_pwm));
        chk("oeb",   32'(pwm_oeb_o), 32'(!m_en));
        chk("irq",   32'(irq_o), 32'(m_wrap & m_irqen));
    endtask

    task automatic wb_xfer(input logic w, input logic [1:0] off, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] rd);
        int lat;
        lat = -1;
        rd  = '0;
        cyc = 1; stb = 1; we = w; adr = BASE + {28'd0, off, 2'b00}; sel = s; dat = d;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (wbs_ack_o === 1'b1) begin
                lat = i;
                rd  = wbs_dat_o;
                break;
            end
        end
        cyc = 0; stb = 0; we = 0;
        chk("ack_latency", 32'(lat), 32'd0);
        tick();
    endtask

    task automatic wb_write(input logic [1:0] off, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] rd;
        wb_xfer(1'b1, off, s, d, rd);
    endtask

    task automatic wb_read(input logic [1:0] off, output logic [31:0] rd);
        wb_xfer(1'b0, off, 4'hF, 32'd0, rd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic count_ones(input int n, output int ones);
        ones = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (pwm_o === 1'b1) ones++;
        end
    endtask

    task automatic wait_phase(input logic [31:0] ph, input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (m_phase == ph) begin found = 1; break; end
            tick();
        end
        chk(name, 32'(found), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        logic [31:0] rd;
        for (int r = 0; r < 4; r++) begin
            wb_read(2'(r), rd);
            chk($sformatf("%s_reg%0d", tag, r), rd, 32'd0);
        end
    endtask

    typedef struct {
        string       name;
        logic [1:0]  off;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] rd;
    int          ones, acks;

    initial begin
        vecs[0] = '{"period_rw",    2'd1, 4'hF, 32'h0000_000A, 32'h0000_000A};
        vecs[1] = '{"duty_lane0",   2'd2, 4'h1, 32'h0000_1234, 32'h0000_0034};
        vecs[2] = '{"duty_lane1",   2'd2, 4'h2, 32'hABCD_5678, 32'h0000_5634};
        vecs[3] = '{"duty_trunc",   2'd2, 4'hF, 32'hFFFF_FFFF, 32'h0000_FFFF};
        vecs[4] = '{"ctrl_rsvd",    2'd0, 4'hF, 32'hFFFF_FFF8, 32'h0000_0000};
        vecs[5] = '{"ctrl_bits",    2'd0, 4'h1, 32'h0000_0006, 32'h0000_0006};
        vecs[6] = '{"ctrl_nosel",   2'd0, 4'hE, 32'h0000_0001, 32'h0000_0006};
        vecs[7] = '{"status_ro",    2'd3, 4'hF, 32'h8000_0000, 32'h0000_0000};
        vecs[8] = '{"period_trunc", 2'd1, 4'hF, 32'h0001_0005, 32'h0000_0005};
        vecs[9] = '{"ctrl_clear",   2'd0, 4'hF, 32'h0000_0000, 32'h0000_0000};

        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(wbs_ack_o), 32'd0);
        chk("rst_dat", wbs_dat_o, 32'd0);
        chk("rst_pwm", 32'(pwm_o), 32'd0);
        chk("rst_oeb", 32'(pwm_oeb_o), 32'd1);
        chk("rst_irq", 32'(irq_o), 32'd0);
        rst_n = 1'b1;
        idle(2);
        check_all_zero("rst");

        for (int i = 0; i < 10; i++) begin
            wb_write(vecs[i].off, vecs[i].sel, vecs[i].wdat);
            wb_read(vecs[i].off, rd);
            chk(vecs[i].name, rd, vecs[i].exp);
        end

        // Basic 3/10 waveform
        wb_write(2'd1, 4'hF, 32'd10);
        wb_write(2'd2, 4'hF, 32'd3);
        wb_write(2'd0, 4'hF, 32'd1);
        chk("oeb_enabled", 32'(pwm_oeb_o), 32'd0);
        idle(15);
        count_ones(10, ones);
        chk("duty3_window", 32'(ones), 32'd3);

        // Duty change mid-period only applies from the next period
        wait_phase(32'd1, "reach_phase1");
        wb_write(2'd2, 4'hF, 32'd7);
        count_ones(7, ones);
        chk("old_duty_kept", 32'(ones), 32'd0);
        idle(20);
        count_ones(10, ones);
        chk("duty7_window", 32'(ones), 32'd7);

        // Duty >= period, inversion, zero period
        wb_write(2'd2, 4'hF, 32'd12);
        idle(25);
        count_ones(10, ones);
        chk("duty_ge_period", 32'(ones), 32'd10);
        wb_write(2'd0, 4'hF, 32'd3);
        idle(3);
        count_ones(10, ones);
        chk("inv_full", 32'(ones), 32'd0);
        wb_write(2'd0, 4'hF, 32'd1);
        wb_write(2'd1, 4'hF, 32'd0);
        idle(25);
        wb_write(2'd3, 4'h8, 32'h8000_0000);
        idle(5);
        count_ones(10, ones);
        chk("period0_low", 32'(ones), 32'd0);
        wb_read(2'd3, rd);
        chk("period0_nowrap", rd, 32'd0);

        // WRAP flag and interrupt
        wb_write(2'd0, 4'hF, 32'd0);
        wb_write(2'd1, 4'hF, 32'd4);
        wb_write(2'd3, 4'hF, 32'h8000_0000);
        wb_write(2'd0, 4'hF, 32'd5);
        idle(2);
        chk("irq_before_wrap", 32'(irq_o), 32'd0);
        idle(1);
        chk("irq_after_wrap", 32'(irq_o), 32'd1);
        wait_phase(32'd0, "reach_phase0");
        wb_write(2'd3, 4'h8, 32'h8000_0000);
        chk("w1c_clears", 32'(irq_o), 32'd0);
        wait_phase(32'd3, "reach_phase3");
        wb_write(2'd3, 4'h8, 32'h8000_0000);
        chk("wrap_set_wins", 32'(irq_o), 32'd1);

        // Access just outside the window
        cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = BASE + 32'h10; dat = 32'hFFFF_FFFF;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (wbs_ack_o === 1'b1) acks++;
        end
        cyc = 0; stb = 0; we = 0;
        chk("miss_no_ack", 32'(acks), 32'd0);
        tick();
        wb_read(2'd0, rd);
        chk("miss_no_effect", rd, 32'd5);

        // Asynchronous reset in the middle of a period
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pwm", 32'(pwm_o), 32'd0);
        chk("async_rst_oeb", 32'(pwm_oeb_o), 32'd1);
        chk("async_rst_ack", 32'(wbs_ack_o), 32'd0);
        chk("async_rst_irq", 32'(irq_o), 32'd0);
        model_reset();
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check_all_zero("midrst");

        // Random register traffic against the model
        for (int i = 0; i < 250; i++) begin
            int          kind;
            logic [1:0]  off;
            logic [3:0]  s;
            logic [31:0] d;
            kind = $urandom_range(0, 9);
            off  = 2'($urandom_range(0, 3));
            s    = (kind < 2) ? 4'($urandom) : 4'hF;
            case (off)
                2'd0:    d = 32'($urandom_range(0, 7)) | (($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0);
                2'd1:    d = 32'($urandom_range(0, 12));
                2'd2:    d = 32'($urandom_range(0, 14));
                default: d = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'($urandom);
            endcase
            if (kind < 7) wb_write(off, s, d);
            else          wb_read(off, rd);
            idle($urandom_range(0, 6));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
